// File: rtl/mul_sequencer.sv
// mul_sequencer
// Iterative unsigned multiplier that owns the HI/LO register pair used by
// multu/mfhi/mflo. A start from the decoder captures both operands and then
// retires BITS_PER_CYCLE multiplier bits per clock for N = WIDTH/BITS_PER_CYCLE
// cycles. The full 2*WIDTH product is committed to {hi,lo} in one step on the
// final iteration. While a multiply is in flight, any new start or HI/LO read
// stalls the issuing instruction.
//
// Ports
//   clk      in   clock, rising edge
//   reset    in   synchronous active-low reset
//   start    in   begin multu (decoder domul), accepted only when idle
//   opa      in   multiplicand, captured on an accepted start
//   opb      in   multiplier, captured on an accepted start
//   rd_req   in   HI/LO read request (decoder multoreg)
//   lohi     in   read select: 0 = LO, 1 = HI
//   rd_data  out  committed HI or LO selected by lohi (combinational)
//   busy     out  multiply in progress
//   stall    out  (start | rd_req) & busy (combinational)
//   hi       out  committed HI register
//   lo       out  committed LO register
//
// state | meaning
// IDLE  | no multiply in flight; start is accepted, reads are served at once
// RUN   | iterating; hi/lo hold the previous product, requests are stalled

module mul_sequencer #(
   parameter int WIDTH          = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             rd_req,
   input  logic             lohi,
   output logic [WIDTH-1:0] rd_data,
   output logic             busy,
   output logic             stall,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N     = WIDTH / BITS_PER_CYCLE;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   mcand_q;
   logic [2*WIDTH-1:0]   acc_q;
   logic [2*WIDTH-1:0]   partial;
   logic [2*WIDTH-1:0]   acc_sum;
   logic [WIDTH-1:0]     mplier_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 accept;
   logic                 last;

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               last    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stall   = (start | rd_req) & busy;
   assign rd_data = lohi ? hi : lo;

   // The multiplicand register is pre-widened and shifted left each cycle, so
   // the current digit's weight is already applied; the digit multiply is
   // only BITS_PER_CYCLE bits wide after constant propagation.
   assign partial = mcand_q * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}},
                               mplier_q[BITS_PER_CYCLE-1:0]};
   assign acc_sum = acc_q + partial;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         hi       <= '0;
         lo       <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mcand_q  <= {{WIDTH{1'b0}}, opa};
            mplier_q <= opb;
            acc_q    <= '0;
            cnt_q    <= CNT_LOAD;
         end else if (state_q == RUN) begin
            acc_q    <= acc_sum;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            if (last) begin
               {hi, lo} <= acc_sum;
            end else begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Iterative multi-cycle unsigned multiplier controller that owns the HI/LO register pair for multu/mfhi/mflo. The decoder's domul starts an operation. The multoreg/lohi pair requests a HI/LO read. While a multiply is in flight, the block raises stall so the core freezes the issuing instruction, replacing the single-cycle combinational multiply.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits (HI = upper WIDTH, LO = lower WIDTH).
BITS_PER_CYCLE, 1, multiplier bits retired per cycle; must divide WIDTH; N = WIDTH/BITS_PER_CYCLE iterations.

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  begin multu (driven from decoder domul)
opa  in  WIDTH  multiplicand (rs value), sampled when start accepted
opb  in  WIDTH  multiplier (rt value), sampled when start accepted
rd_req  in  1  HI/LO read request (decoder multoreg)
lohi  in  1  read select: 0 = LO, 1 = HI
rd_data  out  WIDTH  committed HI or LO per lohi, combinational
busy  out  1  multiply in progress
stall  out  1  combinational: (start | rd_req) & busy
hi  out  WIDTH  committed HI register
lo  out  WIDTH  committed LO register

Behaviour:
- Reset (reset==0 at rising edge) has priority over everything.
  - State goes to IDLE; hi=0, lo=0, busy=0, iteration counter=0, accumulator=0.
  - Reset mid-operation aborts the operation; no partial result is committed.
- FSM states: IDLE, RUN.
  - IDLE: start==1 at edge k captures opa/opb into internal regs, clears the 2*WIDTH accumulator, loads counter=N-1, and moves to RUN.
  - RUN: each edge adds (multiplicand << shift) × (next BITS_PER_CYCLE multiplier LSBs) into the accumulator. The multiplier register shifts right by BITS_PER_CYCLE and the counter decrements.
  - On the edge where counter==0 is processed, the final product is written atomically to {hi,lo} and the FSM returns to IDLE.
- Latency:
  - busy=1 in cycles k+1 … k+N.
  - The new hi/lo are visible from cycle k+N+1.
  - With defaults, busy stays high for exactly 32 cycles.
- hi/lo hold their previous values throughout RUN. The accumulator is internal and never exposed.
- Arithmetic is unsigned; the full 2*WIDTH product has no overflow or truncation.
- start while busy: ignored, no restart, no capture; stall=1. The core re-presents start after busy falls, and it is then accepted in IDLE.
- rd_req while busy: stall=1; rd_data shows the old committed value and must not be consumed.
- rd_req in the completion cycle (busy still 1): stall=1. The next cycle returns the new value with stall=0.
- rd_req in IDLE: stall=0; rd_data = lohi ? hi : lo in the same cycle, with no state change.
- start and rd_req both high in IDLE: start is accepted; rd_data reflects the pre-multiply hi/lo.
- start in IDLE does not itself stall (stall=0 that cycle); busy rises next cycle.
- Back-to-back: a start in the first IDLE cycle after completion is accepted normally.
- Operands of 0 still take the full N cycles; there is no early termination.

Test Plan:
- Reset, then start with opa=3, opb=5 → busy high for 32 cycles, then lo=0x0000000F, hi=0; mflo (rd_req=1, lohi=0) returns 15 with stall=0.
- opa=0xFFFFFFFF, opb=0xFFFFFFFF → after 32 busy cycles hi=0xFFFFFFFE, lo=0x00000001; mfhi returns 0xFFFFFFFE.
- Start 0x10000×0x10000, then rd_req=1, lohi=1 on cycle k+5 → stall=1 until busy falls. The first unstalled read gives hi=0x00000001; lo=0.
- Prior hi/lo=0x11/0x22; start 7×9, assert start again mid-run with opa=2, opb=2 → second start ignored (stall=1), result lo=63, hi=0. Hi/lo read 0x11/0x22 during the run.
- Start 6×7, drop reset at cycle k+10 for one cycle → busy=0, hi=lo=0 next cycle, and the result is never committed.
- BITS_PER_CYCLE=4: 0x12345678×0x9ABCDEF0 → busy exactly 8 cycles, hi=0x0B00EA4E, lo=0x242D2080.
